regfile_wb_arbiter: RTL

- Shares the general-purpose register file's single write port between two writeback sources: the ALU result path and the instruction-decode (immediate/move) path.
- Serialises simultaneous requests through a one-entry skid buffer and drives the register file's write_addr / write_value_* / write_data_sel / write_enable from registered outputs.
- Exposes a per-register pending-write scoreboard so decode can stall reads of registers whose write has not yet landed.

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_skid.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    // write_data_sel encodings seen by the register file
    localparam logic SEL_ALU = 1'b1;
    localparam logic SEL_ID  = 1'b0;

    // EMPTY: both sources may be accepted; HELD: a deferred ID write is buffered
    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_skid.sv
// One-entry holding register for an ID write that lost a same-cycle race to the ALU.
module wb_skid_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              unload,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              full,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_data
);

    // Capture on load, release on unload; reset drops any held entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full     <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else begin
            if (load) begin
                full     <= 1'b1;
                buf_addr <= load_addr;
                buf_data <= load_data;
            end else if (unload) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the ALU and ID
// writeback paths, and reports which registers still have a write in flight.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ADDR_W-1:0] id_addr,
    input  logic [DATA_W-1:0] id_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              hazard1,
    output logic              hazard2,
    output logic              hazard_br,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_value_alu,
    output logic [DATA_W-1:0] write_value_id,
    output logic              write_data_sel,
    output logic              write_enable,
    output logic              busy
);

    import regfile_wb_arbiter_pkg::*;

    arb_state_t          state, next_state;
    logic                buf_full;
    logic [ADDR_W-1:0]   buf_addr;
    logic [DATA_W-1:0]   buf_data;
    logic                buf_load, buf_unload;
    logic                issue_en, issue_sel;
    logic [ADDR_W-1:0]   issue_addr;
    logic [DATA_W-1:0]   issue_data;
    logic [NUM_REGS-1:0] pending;

    wb_skid_buffer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (buf_load),
        .unload   (buf_unload),
        .load_addr(id_addr),
        .load_data(id_data),
        .full     (buf_full),
        .buf_addr (buf_addr),
        .buf_data (buf_data)
    );

    assign busy = buf_full;

    // Arbitration state register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (reset) state <= EMPTY;
        else       state <= next_state;
    end

    // Next-state, readiness and write selection; readies depend on state only
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state = state;
        alu_ready  = 1'b0;
        id_ready   = 1'b0;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        issue_en   = 1'b0;
        issue_sel  = SEL_ID;
        issue_addr = '0;
        issue_data = '0;
        unique case (state)
            EMPTY: begin
                alu_ready = 1'b1;
                id_ready  = 1'b1;
                if (alu_valid) begin
                    // ALU wins a same-cycle race so a colliding ID value lands last
                    issue_en   = 1'b1;
                    issue_sel  = SEL_ALU;
                    issue_addr = alu_addr;
                    issue_data = alu_data;
                    if (id_valid) begin
                        buf_load   = 1'b1;
                        next_state = HELD;
                    end
                end else if (id_valid) begin
                    issue_en   = 1'b1;
                    issue_sel  = SEL_ID;
                    issue_addr = id_addr;
                    issue_data = id_data;
                end
            end
            HELD: begin
                issue_en   = 1'b1;
                issue_sel  = SEL_ID;
                issue_addr = buf_addr;
                issue_data = buf_data;
                buf_unload = 1'b1;
                next_state = EMPTY;
            end
            default: next_state = EMPTY;
        endcase
    end

    // Registered write port; address/select/data hold while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_enable    <= 1'b0;
            write_addr      <= '0;
            write_data_sel  <= SEL_ID;
            write_value_alu <= '0;
            write_value_id  <= '0;
        end else begin
            write_enable <= issue_en;
            if (issue_en) begin
                write_addr     <= issue_addr;
                write_data_sel <= issue_sel;
                if (issue_sel == SEL_ALU) write_value_alu <= issue_data;
                else                      write_value_id  <= issue_data;
            end
        end
    end

    // Pending-write scoreboard: registered write plus any buffered entry
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pending[r] = (write_enable && (write_addr == ADDR_W'(r))) ||
                         (buf_full && (buf_addr == ADDR_W'(r)));
        end
    end

    assign hazard1   = pending[read_addr1];
    assign hazard2   = pending[read_addr2];
    assign hazard_br = pending[br_addr];

endmodule
